// File: rtl/huc6270_cpu_if.sv
// HuC6270 VDC host bus interface: AR/data decode, register commit, VRAM handshakes.
// Optional HUC6270_BUS_SYNC_EN adds 2-flop synchronizers on the CPU bus pins.
module huc6270_cpu_if #(
    parameter int NREGS   = 20,
    parameter int VWR_IDX = 2,
    parameter int VRR_IDX = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cs_n,
    input  logic             wr_n,
    input  logic             rd_n,
    input  logic [1:0]       addr,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    output logic [4:0]       ar,
    output logic [15:0]      reg_wdata,
    output logic [NREGS-1:0] reg_load,
    output logic             vwr_req,
    output logic [15:0]      vwr_data,
    input  logic             vwr_ack,
    input  logic [15:0]      vrr_data,
    output logic             vrr_read,
    input  logic [5:0]       status_in,
    output logic             status_clear
);

    localparam logic [12:0] BUS_IDLE = {3'b111, 10'b0};

    logic [12:0] bus_raw;
    logic [12:0] bus;

    assign bus_raw = {cs_n, wr_n, rd_n, addr, din};

`ifdef HUC6270_BUS_SYNC_EN
    logic [12:0] sync1_q, sync1_d;
    logic [12:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = bus_raw;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= BUS_IDLE;
            sync2_q <= BUS_IDLE;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign bus = sync2_q;
`else
    assign bus = bus_raw;
`endif

    logic       b_cs_n, b_wr_n, b_rd_n;
    logic [1:0] b_addr;
    logic [7:0] b_din;

    assign {b_cs_n, b_wr_n, b_rd_n, b_addr, b_din} = bus;

    logic wact, ract, wstb, rstb;
    logic wact_q, wact_d, ract_q, ract_d;

    assign wact = ~b_cs_n & ~b_wr_n;
    assign ract = ~b_cs_n & ~b_rd_n;
    assign wstb = wact & ~wact_q;
    // A simultaneous write wins; the read edge is dropped.
    assign rstb = ract & ~ract_q & ~wstb;

    logic [4:0]       ar_q, ar_d;
    logic [7:0]       lo_q, lo_d;
    logic [15:0]      reg_wdata_q, reg_wdata_d;
    logic [NREGS-1:0] reg_load_q, reg_load_d;
    logic             vwr_req_q, vwr_req_d;
    logic [15:0]      vwr_data_q, vwr_data_d;
    logic [7:0]       dout_q, dout_d;
    logic             vrr_read_q, vrr_read_d;
    logic             status_clear_q, status_clear_d;
    logic             overrun_q, overrun_d;

    logic [15:0] commit_word;
    assign commit_word = {b_din, lo_q};

    always_comb begin
        wact_d         = wact;
        ract_d         = ract;
        ar_d           = ar_q;
        lo_d           = lo_q;
        reg_wdata_d    = reg_wdata_q;
        reg_load_d     = '0;
        vwr_req_d      = vwr_req_q;
        vwr_data_d     = vwr_data_q;
        dout_d         = dout_q;
        vrr_read_d     = 1'b0;
        status_clear_d = 1'b0;
        overrun_d      = overrun_q;

        if (vwr_ack) vwr_req_d = 1'b0;

        if (wstb) begin
            case (b_addr)
                2'd0: ar_d = b_din[4:0];
                2'd2: lo_d = b_din;
                2'd3: begin
                    reg_wdata_d = commit_word;
                    if (int'(ar_q) < NREGS)
                        reg_load_d = {{(NREGS-1){1'b0}}, 1'b1} << ar_q;
                    if (ar_q == 5'(VWR_IDX)) begin
                        // Overwriting an unacked request loses data: flag it.
                        if (vwr_req_q && !vwr_ack) overrun_d = 1'b1;
                        vwr_req_d  = 1'b1;
                        vwr_data_d = commit_word;
                    end
                end
                default: ;
            endcase
        end else if (rstb) begin
            case (b_addr)
                2'd0: begin
                    dout_d         = {overrun_q, vwr_req_q, status_in};
                    status_clear_d = 1'b1;
                    overrun_d      = 1'b0;
                end
                2'd1: dout_d = 8'h00;
                2'd2: dout_d = vrr_data[7:0];
                default: begin
                    dout_d = vrr_data[15:8];
                    if (ar_q == 5'(VRR_IDX)) vrr_read_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wact_q         <= 1'b0;
            ract_q         <= 1'b0;
            ar_q           <= '0;
            lo_q           <= '0;
            reg_wdata_q    <= '0;
            reg_load_q     <= '0;
            vwr_req_q      <= 1'b0;
            vwr_data_q     <= '0;
            dout_q         <= '0;
            vrr_read_q     <= 1'b0;
            status_clear_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            wact_q         <= wact_d;
            ract_q         <= ract_d;
            ar_q           <= ar_d;
            lo_q           <= lo_d;
            reg_wdata_q    <= reg_wdata_d;
            reg_load_q     <= reg_load_d;
            vwr_req_q      <= vwr_req_d;
            vwr_data_q     <= vwr_data_d;
            dout_q         <= dout_d;
            vrr_read_q     <= vrr_read_d;
            status_clear_q <= status_clear_d;
            overrun_q      <= overrun_d;
        end
    end

    assign dout         = dout_q;
    assign ar           = ar_q;
    assign reg_wdata    = reg_wdata_q;
    assign reg_load     = reg_load_q;
    assign vwr_req      = vwr_req_q;
    assign vwr_data     = vwr_data_q;
    assign vrr_read     = vrr_read_q;
    assign status_clear = status_clear_q;

endmodule

// File: tb/tb_huc6270_cpu_if.sv
// Directed bench for huc6270_cpu_if; expected values are hand-computed.
module tb_huc6270_cpu_if;

`ifdef HUC6270_BUS_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cs_n = 1'b1, wr_n = 1'b1, rd_n = 1'b1;
    logic [1:0]  addr = '0;
    logic [7:0]  din = '0;
    logic [7:0]  dout;
    logic [4:0]  ar;
    logic [15:0] reg_wdata;
    logic [19:0] reg_load;
    logic        vwr_req;
    logic [15:0] vwr_data;
    logic        vwr_ack = 1'b0;
    logic [15:0] vrr_data = '0;
    logic        vrr_read;
    logic [5:0]  status_in = '0;
    logic        status_clear;

    int total = 0;
    int bad = 0;

    huc6270_cpu_if dut (
        .clock(clock), .reset_n(reset_n), .cs_n(cs_n), .wr_n(wr_n),
        .rd_n(rd_n), .addr(addr), .din(din), .dout(dout), .ar(ar),
        .reg_wdata(reg_wdata), .reg_load(reg_load), .vwr_req(vwr_req),
        .vwr_data(vwr_data), .vwr_ack(vwr_ack), .vrr_data(vrr_data),
        .vrr_read(vrr_read), .status_in(status_in),
        .status_clear(status_clear)
    );

    always #5 clock = ~clock;

    task automatic idle_bus();
        cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
    endtask

    // Returns at the first negedge where the write's effect is visible.
    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clock);
        cs_n = 1'b0; wr_n = 1'b0; addr = a; din = d;
        @(negedge clock);
        idle_bus();
        repeat (LAT-1) @(negedge clock);
    endtask

    task automatic rd(input logic [1:0] a);
        @(negedge clock);
        cs_n = 1'b0; rd_n = 1'b0; addr = a;
        @(negedge clock);
        idle_bus();
        repeat (LAT-1) @(negedge clock);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        total++;
        if ({dout, ar, reg_wdata, reg_load, vwr_req, vwr_data, vrr_read,
             status_clear} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got dout=%h ar=%h wd=%h ld=%h req=%b vd=%h want all 0",
                     dout, ar, reg_wdata, reg_load, vwr_req, vwr_data);
        end
    endtask

    task automatic test_commit();
        wr(2'd0, 8'h05);
        total++;
        if (ar !== 5'h05) begin bad++; $display("FAIL ar_write got %h want 05", ar); end
        wr(2'd1, 8'h1F);
        total++;
        if (ar !== 5'h05) begin bad++; $display("FAIL addr1_noeffect got %h want 05", ar); end
        wr(2'd2, 8'h34);
        wr(2'd3, 8'h12);
        total++;
        if (reg_load !== 20'h00020) begin
            bad++; $display("FAIL load_pulse got %h want 00020", reg_load);
        end
        total++;
        if (reg_wdata !== 16'h1234) begin
            bad++; $display("FAIL reg_wdata got %h want 1234", reg_wdata);
        end
        @(negedge clock);
        total++;
        if (reg_load !== 20'h0) begin
            bad++; $display("FAIL load_one_cycle got %h want 00000", reg_load);
        end
        total++;
        if (vwr_req !== 1'b0) begin bad++; $display("FAIL no_vwr_r5 got %b want 0", vwr_req); end
    endtask

    task automatic test_vwr_ack();
        wr(2'd0, 8'h02);
        wr(2'd2, 8'hCD);
        wr(2'd3, 8'hAB);
        total++;
        if (reg_load !== 20'h00004) begin
            bad++; $display("FAIL load_r2 got %h want 00004", reg_load);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (vwr_req !== 1'b1 || vwr_data !== 16'hABCD) begin
                bad++;
                $display("FAIL vwr_hold%0d got req=%b data=%h want 1 ABCD", i, vwr_req, vwr_data);
            end
            @(negedge clock);
        end
        vwr_ack = 1'b1;
        total++;
        if (vwr_req !== 1'b1) begin bad++; $display("FAIL vwr_ackcycle got %b want 1", vwr_req); end
        @(negedge clock);
        vwr_ack = 1'b0;
        total++;
        if (vwr_req !== 1'b0) begin bad++; $display("FAIL vwr_clear got %b want 0", vwr_req); end
        wr(2'd0, 8'h19);
        wr(2'd3, 8'h77);
        total++;
        if (reg_load !== 20'h0 || reg_wdata !== 16'h77CD) begin
            bad++;
            $display("FAIL ar_oob got ld=%h wd=%h want 00000 77CD", reg_load, reg_wdata);
        end
    endtask

    task automatic test_overrun();
        status_in = 6'h2A;
        wr(2'd0, 8'h02);
        wr(2'd2, 8'h11);
        wr(2'd3, 8'h11);
        wr(2'd2, 8'h22);
        wr(2'd3, 8'h22);
        total++;
        if (vwr_req !== 1'b1 || vwr_data !== 16'h2222) begin
            bad++; $display("FAIL ovr_data got req=%b data=%h want 1 2222", vwr_req, vwr_data);
        end
        rd(2'd0);
        total++;
        if (dout !== 8'hEA) begin bad++; $display("FAIL status_ovr got %h want EA", dout); end
        total++;
        if (status_clear !== 1'b1) begin
            bad++; $display("FAIL status_clear got %b want 1", status_clear);
        end
        @(negedge clock);
        total++;
        if (status_clear !== 1'b0) begin
            bad++; $display("FAIL status_clear_once got %b want 0", status_clear);
        end
        rd(2'd0);
        total++;
        if (dout !== 8'h6A) begin bad++; $display("FAIL status_noovr got %h want 6A", dout); end
    endtask

    task automatic test_ack_same_cycle();
        // vwr_req is still pending from the overrun scenario with 2222h.
        wr(2'd2, 8'h44);
        @(negedge clock);
        cs_n = 1'b0; wr_n = 1'b0; addr = 2'd3; din = 8'h44;
        if (LAT == 1) vwr_ack = 1'b1;
        @(negedge clock);
        idle_bus();
        if (LAT > 1) begin
            repeat (LAT-2) @(negedge clock);
            vwr_ack = 1'b1;
            @(negedge clock);
        end
        vwr_ack = 1'b0;
        total++;
        if (vwr_req !== 1'b1 || vwr_data !== 16'h4444) begin
            bad++; $display("FAIL ack_same got req=%b data=%h want 1 4444", vwr_req, vwr_data);
        end
        rd(2'd0);
        total++;
        if (dout !== 8'h6A) begin bad++; $display("FAIL ack_same_ovr got %h want 6A", dout); end
        @(negedge clock);
        vwr_ack = 1'b1;
        @(negedge clock);
        vwr_ack = 1'b0;
    endtask

    task automatic test_vrr_read();
        int pulses;
        pulses = 0;
        vrr_data = 16'hBEEF;
        wr(2'd0, 8'h02);
        @(negedge clock);
        cs_n = 1'b0; rd_n = 1'b0; addr = 2'd2;
        repeat (LAT) @(negedge clock);
        total++;
        if (dout !== 8'hEF) begin bad++; $display("FAIL vrr_lo got %h want EF", dout); end
        vrr_data = 16'h5555;
        repeat (5 - LAT) begin
            @(negedge clock);
            if (vrr_read) pulses++;
        end
        total++;
        if (dout !== 8'hEF) begin bad++; $display("FAIL held_read got %h want EF", dout); end
        idle_bus();
        vrr_data = 16'hBEEF;
        rd(2'd3);
        total++;
        if (dout !== 8'hBE) begin bad++; $display("FAIL vrr_hi got %h want BE", dout); end
        if (vrr_read) pulses++;
        repeat (3) begin
            @(negedge clock);
            if (vrr_read) pulses++;
        end
        total++;
        if (pulses !== 1) begin bad++; $display("FAIL vrr_pulses got %0d want 1", pulses); end
        rd(2'd1);
        total++;
        if (dout !== 8'h00) begin bad++; $display("FAIL read_a1 got %h want 00", dout); end
    endtask

    task automatic test_wr_rd_same();
        rd(2'd2);
        @(negedge clock);
        cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b0; addr = 2'd0; din = 8'h07;
        @(negedge clock);
        idle_bus();
        repeat (LAT-1) @(negedge clock);
        total++;
        if (ar !== 5'h07 || dout !== 8'hEF || status_clear !== 1'b0) begin
            bad++;
            $display("FAIL wr_wins got ar=%h dout=%h sc=%b want 07 EF 0", ar, dout, status_clear);
        end
    endtask

    task automatic test_reset_midway();
        wr(2'd0, 8'h02);
        wr(2'd2, 8'hAA);
        wr(2'd3, 8'hBB);
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (vwr_req !== 1'b0 || ar !== 5'h0 || vwr_data !== 16'h0) begin
            bad++;
            $display("FAIL reset_mid got req=%b ar=%h vd=%h want 0 00 0000", vwr_req, ar, vwr_data);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_commit();
        test_vwr_ack();
        test_overrun();
        test_ack_same_cycle();
        test_vrr_read();
        test_wr_rd_same();
        test_reset_midway();
        repeat (2) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
